// File: rtl/reg_wb_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : reg_wb_ctrl                                                    |
// | Brief   : In-order register-file writeback queue with RAW scoreboard.    |
// |           Optional macro WB_BYPASS_EN adds write-port bypass outputs.    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module reg_wb_ctrl #(
  parameter int DEPTH = 4,
  parameter int DW    = 8,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          init,
  input  logic          iss_vld,
  output logic          iss_rdy,
  input  logic [AW-1:0] iss_dst,
  input  logic [1:0]    iss_src,
  input  logic [DW-1:0] iss_dat,
  input  logic          mem_vld,
  input  logic [DW-1:0] mem_dat,
  input  logic          lut_vld,
  input  logic [DW-1:0] lut_dat,
  input  logic [AW-1:0] rd_ptr_a,
  input  logic [AW-1:0] rd_ptr_b,
  input  logic          rd_b_used,
  output logic          hazard,
  output logic          wr_en,
  output logic [AW-1:0] wr_ptr,
  output logic [DW-1:0] wr_dat,
`ifdef WB_BYPASS_EN
  output logic          byp_a_vld,
  output logic          byp_b_vld,
  output logic [DW-1:0] byp_dat,
`endif
  output logic          err
);

  localparam int c_PW   = $clog2(DEPTH);
  localparam int c_CW   = c_PW + 1;
  localparam int c_NREG = 1 << AW;

  localparam logic [1:0] c_SRC_ALU = 2'd0;
  localparam logic [1:0] c_SRC_LUT = 2'd2;
  localparam logic [1:0] c_SRC_BAD = 2'd3;

  // Queue storage; MEM vs LUT is the only source distinction needed once queued
  logic [DEPTH-1:0] r_vld;
  logic [DEPTH-1:0] r_rdy;
  logic [DEPTH-1:0] r_lut;
  logic [AW-1:0]    r_dst [DEPTH];
  logic [DW-1:0]    r_dat [DEPTH];
  logic [c_PW-1:0]  r_head;
  logic [c_PW-1:0]  r_tail;
  logic [c_CW-1:0]  r_cnt;

  logic             r_wr_en;
  logic [AW-1:0]    r_wr_ptr;
  logic [DW-1:0]    r_wr_dat;
  logic             r_err;

  logic             w_iss_ok;
  logic             w_iss_bad;
  logic             w_retire;
  logic             w_mem_hit;
  logic             w_lut_hit;
  logic [c_PW-1:0]  w_mem_idx;
  logic [c_PW-1:0]  w_lut_idx;
  logic [c_PW-1:0]  w_scan [DEPTH];
  logic [c_NREG-1:0] w_pend;
  logic             w_hit_a;
  logic             w_hit_b;
  logic             w_fly_a;
  logic             w_fly_b;

  assign iss_rdy   = (r_cnt < c_CW'(DEPTH));
  assign w_iss_ok  = iss_vld & iss_rdy & (iss_src != c_SRC_BAD);
  assign w_iss_bad = iss_vld & iss_rdy & (iss_src == c_SRC_BAD);
  assign w_retire  = r_vld[r_head] & r_rdy[r_head];

  // Slot indices in age order, oldest first
  for (genvar g = 0; g < DEPTH; g++) begin : g_scan
    assign w_scan[g] = r_head + c_PW'(g);
  end

  always_comb begin
    w_mem_hit = 1'b0;
    w_mem_idx = '0;
    w_lut_hit = 1'b0;
    w_lut_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!w_mem_hit && r_vld[w_scan[k]] && !r_rdy[w_scan[k]] && !r_lut[w_scan[k]]) begin
        w_mem_hit = 1'b1;
        w_mem_idx = w_scan[k];
      end
      if (!w_lut_hit && r_vld[w_scan[k]] && !r_rdy[w_scan[k]] && r_lut[w_scan[k]]) begin
        w_lut_hit = 1'b1;
        w_lut_idx = w_scan[k];
      end
    end
  end

  always_comb begin
    w_pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i]) begin
        w_pend[r_dst[i]] = 1'b1;
      end
    end
  end

  assign w_hit_a = w_pend[rd_ptr_a];
  assign w_hit_b = rd_b_used & w_pend[rd_ptr_b];
  assign w_fly_a = r_wr_en & (r_wr_ptr == rd_ptr_a);
  assign w_fly_b = r_wr_en & rd_b_used & (r_wr_ptr == rd_ptr_b);

`ifdef WB_BYPASS_EN
  assign hazard    = w_hit_a | w_hit_b;
  assign byp_a_vld = w_fly_a & ~w_pend[rd_ptr_a];
  assign byp_b_vld = w_fly_b & ~w_pend[rd_ptr_b];
  assign byp_dat   = r_wr_dat;
`else
  assign hazard    = w_hit_a | w_hit_b | w_fly_a | w_fly_b;
`endif

  assign wr_en  = r_wr_en;
  assign wr_ptr = r_wr_ptr;
  assign wr_dat = r_wr_dat;
  assign err    = r_err;

  always_ff @(posedge clk) begin
    if (init) begin
      r_vld    <= '0;
      r_rdy    <= '0;
      r_lut    <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_cnt    <= '0;
      r_wr_en  <= 1'b0;
      r_wr_ptr <= '0;
      r_wr_dat <= '0;
      r_err    <= 1'b0;
    end else begin
      if (mem_vld && w_mem_hit) begin
        r_rdy[w_mem_idx] <= 1'b1;
        r_dat[w_mem_idx] <= mem_dat;
      end
      if (lut_vld && w_lut_hit) begin
        r_rdy[w_lut_idx] <= 1'b1;
        r_dat[w_lut_idx] <= lut_dat;
      end

      if (w_retire) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + c_PW'(1);
        r_wr_ptr      <= r_dst[r_head];
        r_wr_dat      <= r_dat[r_head];
      end
      r_wr_en <= w_retire;

      // Tail slot is free whenever an issue is accepted, so it never collides with a return
      if (w_iss_ok) begin
        r_vld[r_tail] <= 1'b1;
        r_rdy[r_tail] <= (iss_src == c_SRC_ALU);
        r_lut[r_tail] <= (iss_src == c_SRC_LUT);
        r_dst[r_tail] <= iss_dst;
        r_dat[r_tail] <= iss_dat;
        r_tail        <= r_tail + c_PW'(1);
      end

      case ({w_iss_ok, w_retire})
        2'b10:   r_cnt <= r_cnt + c_CW'(1);
        2'b01:   r_cnt <= r_cnt - c_CW'(1);
        default: r_cnt <= r_cnt;
      endcase

      if (w_iss_bad || (mem_vld && !w_mem_hit) || (lut_vld && !w_lut_hit)) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_wb_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_reg_wb_ctrl                                                 |
// | Brief   : Directed bench for reg_wb_ctrl with a queue-based model.       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_reg_wb_ctrl;

  localparam int DEPTH = 4;
  localparam int DW    = 8;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          init;
  logic          iss_vld;
  logic          iss_rdy;
  logic [AW-1:0] iss_dst;
  logic [1:0]    iss_src;
  logic [DW-1:0] iss_dat;
  logic          mem_vld;
  logic [DW-1:0] mem_dat;
  logic          lut_vld;
  logic [DW-1:0] lut_dat;
  logic [AW-1:0] rd_ptr_a;
  logic [AW-1:0] rd_ptr_b;
  logic          rd_b_used;
  logic          hazard;
  logic          wr_en;
  logic [AW-1:0] wr_ptr;
  logic [DW-1:0] wr_dat;
  logic          err;
`ifdef WB_BYPASS_EN
  logic          byp_a_vld;
  logic          byp_b_vld;
  logic [DW-1:0] byp_dat;
`endif

  reg_wb_ctrl #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_dut (
    .clk       (clk),
    .init      (init),
    .iss_vld   (iss_vld),
    .iss_rdy   (iss_rdy),
    .iss_dst   (iss_dst),
    .iss_src   (iss_src),
    .iss_dat   (iss_dat),
    .mem_vld   (mem_vld),
    .mem_dat   (mem_dat),
    .lut_vld   (lut_vld),
    .lut_dat   (lut_dat),
    .rd_ptr_a  (rd_ptr_a),
    .rd_ptr_b  (rd_ptr_b),
    .rd_b_used (rd_b_used),
    .hazard    (hazard),
    .wr_en     (wr_en),
    .wr_ptr    (wr_ptr),
    .wr_dat    (wr_dat),
`ifdef WB_BYPASS_EN
    .byp_a_vld (byp_a_vld),
    .byp_b_vld (byp_b_vld),
    .byp_dat   (byp_dat),
`endif
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: pending writes as an ordered list; returns fill the oldest waiting entry of their kind
  typedef struct packed {
    logic [AW-1:0] dst;
    logic [1:0]    src;
    logic [DW-1:0] dat;
    logic          rdy;
  } ent_t;

  ent_t          mq[$];
  ent_t          m_e;
  ent_t          m_head;
  logic          m_wr_en  = 1'b0;
  logic [AW-1:0] m_wr_ptr = '0;
  logic [DW-1:0] m_wr_dat = '0;
  logic          m_err    = 1'b0;
  int            m_mi;
  int            m_li;
  bit            m_ret;
  bit            m_room;

  initial begin
    forever begin
      @(posedge clk);
      if (init) begin
        mq.delete();
        m_wr_en  = 1'b0;
        m_wr_ptr = '0;
        m_wr_dat = '0;
        m_err    = 1'b0;
      end else begin
        m_mi = -1;
        m_li = -1;
        for (int i = 0; i < mq.size(); i++) begin
          if (m_mi < 0 && mq[i].src == 2'd1 && !mq[i].rdy) m_mi = i;
          if (m_li < 0 && mq[i].src == 2'd2 && !mq[i].rdy) m_li = i;
        end
        m_room = (mq.size() < DEPTH);
        m_ret  = (mq.size() > 0) && mq[0].rdy;
        if (m_ret) m_head = mq[0];
        if (mem_vld) begin
          if (m_mi < 0) m_err = 1'b1;
          else begin
            m_e = mq[m_mi]; m_e.dat = mem_dat; m_e.rdy = 1'b1; mq[m_mi] = m_e;
          end
        end
        if (lut_vld) begin
          if (m_li < 0) m_err = 1'b1;
          else begin
            m_e = mq[m_li]; m_e.dat = lut_dat; m_e.rdy = 1'b1; mq[m_li] = m_e;
          end
        end
        if (m_ret) void'(mq.pop_front());
        if (iss_vld && m_room) begin
          if (iss_src == 2'd3) m_err = 1'b1;
          else begin
            m_e.dst = iss_dst;
            m_e.src = iss_src;
            m_e.dat = (iss_src == 2'd0) ? iss_dat : '0;
            m_e.rdy = (iss_src == 2'd0);
            mq.push_back(m_e);
          end
        end
        m_wr_en = m_ret;
        if (m_ret) begin
          m_wr_ptr = m_head.dst;
          m_wr_dat = m_head.dat;
        end
      end
    end
  end

  // Compare every cycle against the model
  logic pa, pb_raw, fa, fb;
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        pa = 1'b0;
        pb_raw = 1'b0;
        foreach (mq[i]) begin
          if (mq[i].dst == rd_ptr_a) pa = 1'b1;
          if (mq[i].dst == rd_ptr_b) pb_raw = 1'b1;
        end
        fa = m_wr_en && (m_wr_ptr == rd_ptr_a);
        fb = m_wr_en && rd_b_used && (m_wr_ptr == rd_ptr_b);
        check("mdl_iss_rdy", 32'(iss_rdy), 32'(mq.size() < DEPTH));
        check("mdl_wr_en",   32'(wr_en),   32'(m_wr_en));
        check("mdl_wr_ptr",  32'(wr_ptr),  32'(m_wr_ptr));
        check("mdl_wr_dat",  32'(wr_dat),  32'(m_wr_dat));
        check("mdl_err",     32'(err),     32'(m_err));
`ifdef WB_BYPASS_EN
        check("mdl_hazard",    32'(hazard),    32'(pa | (rd_b_used & pb_raw)));
        check("mdl_byp_a_vld", 32'(byp_a_vld), 32'(fa & ~pa));
        check("mdl_byp_b_vld", 32'(byp_b_vld), 32'(fb & ~pb_raw));
        check("mdl_byp_dat",   32'(byp_dat),   32'(m_wr_dat));
`else
        check("mdl_hazard",    32'(hazard),    32'(pa | (rd_b_used & pb_raw) | fa | fb));
`endif
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    iss_vld = 1'b0; mem_vld = 1'b0; lut_vld = 1'b0; init = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_iss(input logic [AW-1:0] d, input logic [1:0] s, input logic [DW-1:0] v);
    iss_vld = 1'b1; iss_dst = d; iss_src = s; iss_dat = v;
  endtask

  initial begin
    init = 1'b1; iss_vld = 1'b0; iss_dst = '0; iss_src = '0; iss_dat = '0;
    mem_vld = 1'b0; mem_dat = '0; lut_vld = 1'b0; lut_dat = '0;
    rd_ptr_a = '0; rd_ptr_b = '0; rd_b_used = 1'b0;
    cyc(); cyc();
    chk_on = 1'b1;
    init = 1'b0;
    @(negedge clk);
    check("rst_iss_rdy", 32'(iss_rdy), 32'd1);
    check("rst_hazard",  32'(hazard),  32'd0);
    check("rst_wr_en",   32'(wr_en),   32'd0);
    check("rst_wr_ptr",  32'(wr_ptr),  32'd0);
    check("rst_wr_dat",  32'(wr_dat),  32'd0);
    check("rst_err",     32'(err),     32'd0);

    // ALU write latency and hazard window
    rd_ptr_a = 4'd3;
    cyc();
    set_iss(4'd3, 2'd0, 8'h5A);
    @(negedge clk); check("t1_c0_hazard", 32'(hazard), 32'd0);
    cyc(); iss_vld = 1'b0;
    @(negedge clk); check("t1_c1_hazard", 32'(hazard), 32'd1);
    check("t1_c1_wr_en", 32'(wr_en), 32'd0);
    cyc();
    @(negedge clk);
    check("t1_c2_wr_en",  32'(wr_en),  32'd1);
    check("t1_c2_wr_ptr", 32'(wr_ptr), 32'd3);
    check("t1_c2_wr_dat", 32'(wr_dat), 32'h5A);
`ifdef WB_BYPASS_EN
    check("t1_c2_hazard", 32'(hazard), 32'd0);
`else
    check("t1_c2_hazard", 32'(hazard), 32'd1);
`endif
    cyc();
    @(negedge clk);
    check("t1_c3_hazard", 32'(hazard), 32'd0);
    check("t1_c3_wr_en",  32'(wr_en),  32'd0);
    check("t1_c3_wr_dat", 32'(wr_dat), 32'h5A);
    idle(2);

    // MEM head blocks a younger ALU entry
    rd_ptr_a = 4'd1; rd_ptr_b = 4'd2; rd_b_used = 1'b1;
    set_iss(4'd1, 2'd1, 8'h00); cyc();
    set_iss(4'd2, 2'd0, 8'h11); cyc();
    iss_vld = 1'b0;
    @(negedge clk); check("t2_c2_wr_en", 32'(wr_en), 32'd0);
    cyc();
    mem_vld = 1'b1; mem_dat = 8'hC3;
    @(negedge clk); check("t2_c3_wr_en", 32'(wr_en), 32'd0);
    check("t2_c3_hazard", 32'(hazard), 32'd1);
    cyc(); mem_vld = 1'b0;
    @(negedge clk); check("t2_c4_wr_en", 32'(wr_en), 32'd0);
    cyc();
    @(negedge clk);
    check("t2_c5_wr_en",  32'(wr_en),  32'd1);
    check("t2_c5_wr_ptr", 32'(wr_ptr), 32'd1);
    check("t2_c5_wr_dat", 32'(wr_dat), 32'hC3);
    cyc();
    @(negedge clk);
    check("t2_c6_wr_en",  32'(wr_en),  32'd1);
    check("t2_c6_wr_ptr", 32'(wr_ptr), 32'd2);
    check("t2_c6_wr_dat", 32'(wr_dat), 32'h11);
    idle(3);

    // Full queue back-pressure
    rd_ptr_a = 4'd15; rd_b_used = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_iss(AW'(5 + i), 2'd1, 8'h00); cyc();
    end
    set_iss(4'd9, 2'd0, 8'h99);
    @(negedge clk); check("t3_full_iss_rdy", 32'(iss_rdy), 32'd0);
    cyc();
    iss_vld = 1'b0; mem_vld = 1'b1; mem_dat = 8'hAB;
    cyc(); mem_vld = 1'b0;
    @(negedge clk); check("t3_c6_iss_rdy", 32'(iss_rdy), 32'd0);
    cyc();
    @(negedge clk);
    check("t3_c7_iss_rdy", 32'(iss_rdy), 32'd1);
    check("t3_c7_wr_ptr",  32'(wr_ptr),  32'd5);
    check("t3_c7_wr_dat",  32'(wr_dat),  32'hAB);
    set_iss(4'd12, 2'd0, 8'h3C); cyc();
    iss_vld = 1'b0;
    @(negedge clk); check("t3_refill_iss_rdy", 32'(iss_rdy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      mem_vld = 1'b1; mem_dat = 8'hB1 + 8'(i); cyc();
    end
    idle(6);
    @(negedge clk); check("t3_err", 32'(err), 32'd0);

    // Unmatched return and illegal source
    lut_vld = 1'b1; lut_dat = 8'hEE; cyc(); lut_vld = 1'b0;
    @(negedge clk); check("t4_lut_err", 32'(err), 32'd1);
    idle(2);
    @(negedge clk); check("t4_err_sticky", 32'(err), 32'd1);
    init = 1'b1; cyc(); init = 1'b0;
    @(negedge clk); check("t4_err_clr", 32'(err), 32'd0);
    rd_ptr_a = 4'd13;
    set_iss(4'd13, 2'd3, 8'h55); cyc(); iss_vld = 1'b0;
    @(negedge clk);
    check("t4_bad_err",    32'(err),    32'd1);
    check("t4_bad_hazard", 32'(hazard), 32'd0);
    idle(2);
    init = 1'b1; cyc(); init = 1'b0;

    // Reset discards pending entries
    rd_ptr_a = 4'd1;
    set_iss(4'd1, 2'd1, 8'h00); cyc();
    set_iss(4'd2, 2'd1, 8'h00); cyc();
    iss_vld = 1'b0; init = 1'b1; cyc(); init = 1'b0;
    @(negedge clk);
    check("t5_iss_rdy", 32'(iss_rdy), 32'd1);
    check("t5_hazard",  32'(hazard),  32'd0);
    check("t5_wr_en",   32'(wr_en),   32'd0);
    mem_vld = 1'b1; mem_dat = 8'h44; cyc(); mem_vld = 1'b0;
    @(negedge clk); check("t5_late_err", 32'(err), 32'd1);
    init = 1'b1; cyc(); init = 1'b0;

    // Simultaneous MEM and LUT returns
    set_iss(4'd10, 2'd1, 8'h00); cyc();
    set_iss(4'd11, 2'd2, 8'h00); cyc();
    iss_vld = 1'b0;
    mem_vld = 1'b1; mem_dat = 8'h21; lut_vld = 1'b1; lut_dat = 8'h42; cyc();
    mem_vld = 1'b0; lut_vld = 1'b0;
    cyc();
    @(negedge clk);
    check("t6_w1_ptr", 32'(wr_ptr), 32'd10);
    check("t6_w1_dat", 32'(wr_dat), 32'h21);
    cyc();
    @(negedge clk);
    check("t6_w2_ptr", 32'(wr_ptr), 32'd11);
    check("t6_w2_dat", 32'(wr_dat), 32'h42);
    check("t6_err",    32'(err),    32'd0);
    idle(2);

    // Write-port bypass window for operand B
    for (int pass = 0; pass < 2; pass++) begin
      rd_ptr_a = 4'd0; rd_ptr_b = 4'd4; rd_b_used = (pass == 0);
      set_iss(4'd4, 2'd0, 8'h77); cyc(); iss_vld = 1'b0;
      cyc();
      @(negedge clk);
      check("t7_wr_en", 32'(wr_en), 32'd1);
`ifdef WB_BYPASS_EN
      check("t7_hazard",    32'(hazard),    32'd0);
      check("t7_byp_b_vld", 32'(byp_b_vld), (pass == 0) ? 32'd1 : 32'd0);
      check("t7_byp_dat",   32'(byp_dat),   32'h77);
`else
      check("t7_hazard",    32'(hazard),    (pass == 0) ? 32'd1 : 32'd0);
`endif
      idle(2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
